// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target serving a byte-addressed register file.
//   First written byte sets the register pointer, later bytes are data, and
//   the pointer auto-increments (mod MEM_DEPTH) on every write and ACKed read.
//   Lines are open-drain: the block only ever asserts pull-low enables.
// Optional feature macro: I2C_SLV_CLK_STRETCH_EN (SCL stretch after ACK slots).
// Ports:
//   i2c_core_clk_i  core clock (>= 8x SCL), all logic on its rising edge
//   i2c_rst_ni      synchronous active-low reset
//   scl_i, sda_i    bus levels
//   sda_oe_o        1 = pull SDA low
//   scl_oe_o        1 = pull SCL low (clock stretch)
//   busy_o          addressed transfer in progress (until STOP)
//   wr_strobe_o     one-cycle pulse per data byte written, with wr_addr_o/wr_data_o
//   rd_strobe_o     one-cycle pulse when a byte is loaded for transmission
module i2c_slave_responder #(
    parameter logic [6:0]  SLV_ADDR    = 7'h50,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned STRETCH_CYC = 8
) (
    input  logic       i2c_core_clk_i,
    input  logic       i2c_rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic       busy_o,
    output logic       wr_strobe_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       rd_strobe_o
);

    localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0]  PTR_MASK = 8'(MEM_DEPTH - 1);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWack, StRdata, StRack, StIgnore
    } state_e;

    // [0],[1] synchronize, [2] is the previous synced value for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_rise, scl_fall, sda_lvl, start_det, stop_det;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d, ptr_inc;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_strobe_q, rd_strobe_d;
    logic       mem_we;
    logic       ack_slot_end;
    logic       scl_stretch;
    logic [7:0] mem_q [MEM_DEPTH];

    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign sda_lvl   = sda_sync_q[1];
    assign start_det = sda_sync_q[2] & ~sda_sync_q[1] & scl_sync_q[1] & scl_sync_q[2];
    assign stop_det  = ~sda_sync_q[2] & sda_sync_q[1] & scl_sync_q[1] & scl_sync_q[2];
    assign ptr_inc   = (ptr_q + 8'd1) & PTR_MASK;

    // State register (plus datapath registers and memory)
    always_ff @(posedge i2c_core_clk_i) begin
        if (!i2c_rst_ni) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            scl_sync_q  <= {scl_sync_q[1:0], scl_i};
            sda_sync_q  <= {sda_sync_q[1:0], sda_i};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            if (mem_we) mem_q[ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        ack_d        = ack_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_strobe_d  = 1'b0;
        mem_we       = 1'b0;
        ack_slot_end = 1'b0;
        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            // Repeated START aborts anything, including an ACK slot; pointer kept
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {StAddr, StPtr, StWdata})) begin
                shift_d   = {shift_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                StAddr: if (scl_fall && bit_cnt_q == 4'd8) begin
                    // Address 0 (general call) is never acknowledged
                    if (shift_q[7:1] == SLV_ADDR && shift_q[7:1] != 7'd0) begin
                        state_d  = StAddrAck;
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        busy_d   = 1'b1;
                    end else begin
                        state_d = StIgnore;
                    end
                end
                StAddrAck: if (scl_fall) begin
                    ack_slot_end = 1'b1;
                    bit_cnt_d    = '0;
                    if (rw_q) begin
                        state_d     = StRdata;
                        shift_d     = mem_q[ptr_q[AW-1:0]];
                        sda_oe_d    = ~mem_q[ptr_q[AW-1:0]][7];
                        rd_strobe_d = 1'b1;
                    end else begin
                        state_d  = StPtr;
                        sda_oe_d = 1'b0;
                    end
                end
                StPtr: if (scl_fall && bit_cnt_q == 4'd8) begin
                    ptr_d    = shift_q & PTR_MASK;
                    state_d  = StPtrAck;
                    sda_oe_d = 1'b1;
                end
                StWdata: if (scl_fall && bit_cnt_q == 4'd8) begin
                    mem_we      = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = shift_q;
                    ptr_d       = ptr_inc;
                    state_d     = StWack;
                    sda_oe_d    = 1'b1;
                end
                StPtrAck, StWack: if (scl_fall) begin
                    ack_slot_end = 1'b1;
                    state_d      = StWdata;
                    sda_oe_d     = 1'b0;
                    bit_cnt_d    = '0;
                end
                StRdata: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d  = StRack;
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StRack: begin
                    if (scl_rise) ack_d = ~sda_lvl;
                    if (scl_fall) begin
                        ack_slot_end = 1'b1;
                        if (ack_q) begin
                            ptr_d       = ptr_inc;
                            shift_d     = mem_q[ptr_inc[AW-1:0]];
                            sda_oe_d    = ~mem_q[ptr_inc[AW-1:0]][7];
                            rd_strobe_d = 1'b1;
                            bit_cnt_d   = '0;
                            state_d     = StRdata;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_SLV_CLK_STRETCH_EN
    logic        scl_oe_q;
    logic [15:0] stretch_cnt_q;

    // Holds SCL low for STRETCH_CYC cycles after each ACK slot
    always_ff @(posedge i2c_core_clk_i) begin
        if (!i2c_rst_ni) begin
            scl_oe_q      <= 1'b0;
            stretch_cnt_q <= '0;
        end else if (stop_det || start_det) begin
            scl_oe_q <= 1'b0;
        end else if (ack_slot_end && STRETCH_CYC > 0) begin
            scl_oe_q      <= 1'b1;
            stretch_cnt_q <= 16'(STRETCH_CYC - 1);
        end else if (scl_oe_q) begin
            if (stretch_cnt_q == '0) scl_oe_q <= 1'b0;
            else stretch_cnt_q <= stretch_cnt_q - 16'd1;
        end
    end
    assign scl_stretch = scl_oe_q;
`else
    logic unused_ack_slot_end;
    assign unused_ack_slot_end = ack_slot_end;
    assign scl_stretch         = 1'b0;
`endif

    // Output logic
    always_comb begin
        sda_oe_o    = sda_oe_q;
        scl_oe_o    = scl_stretch;
        busy_o      = busy_q;
        wr_strobe_o = wr_strobe_q;
        wr_addr_o   = wr_addr_q;
        wr_data_o   = wr_data_q;
        rd_strobe_o = rd_strobe_q;
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: a bit-banged I2C master drives
// directed and random transfers; a transaction-level model (register array,
// pointer, expected-write queue) predicts ACKs, read data and write strobes.
module tb_i2c_slave_responder;

    localparam int Q = 4;  // core cycles per SCL quarter phase

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sda_oe, scl_oe, busy, wr_strobe, rd_strobe;
    logic [7:0] wr_addr, wr_data;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [7:0]  mem_m [16];
    int          ptr_m = 0;
    logic [15:0] exp_wr[$];
    logic [15:0] e_wr;
    int          rd_cnt = 0;
    bit          quiet = 1'b0;
    bit          mon_en = 1'b0;
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [4];

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder dut (
        .i2c_core_clk_i (clk),
        .i2c_rst_ni     (rst_n),
        .scl_i          (scl_bus),
        .sda_i          (sda_bus),
        .sda_oe_o       (sda_oe),
        .scl_oe_o       (scl_oe),
        .busy_o         (busy),
        .wr_strobe_o    (wr_strobe),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .rd_strobe_o    (rd_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare process
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    check("wr_strobe_unexpected", {31'd0, wr_strobe}, 32'd0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e_wr[15:8]});
                    check("wr_data", {24'd0, wr_data}, {24'd0, e_wr[7:0]});
                end
            end
            if (rd_strobe) rd_cnt++;
`ifndef I2C_SLV_CLK_STRETCH_EN
            check("scl_oe_tied_low", {31'd0, scl_oe}, 32'd0);
`endif
            if (quiet) begin
                check("quiet_sda_oe", {31'd0, sda_oe}, 32'd0);
                check("quiet_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    // Release SCL and wait (bounded) until the bus is actually high
    task automatic scl_high();
        int n = 0;
        scl_m = 1'b1;
        while (scl_bus !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        wq();
        scl_high();
        wq();
        s = sda_bus;
        wq();
        scl_m = 1'b0;
        wq();
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wq();
        scl_high();
        wq();
        sda_m = 1'b0;
        wq();
        scl_m = 1'b0;
        wq();
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wq();
        scl_high();
        wq();
        sda_m = 1'b1;
        wq();
        wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            b = {b[6:0], s};
        end
        bit_xfer(nack, s);
    endtask

    task automatic finish_stop();
        stop_c();
        repeat (6) @(negedge clk);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("sda_rel_after_stop", {31'd0, sda_oe}, 32'd0);
        check("wr_pending", exp_wr.size(), 32'd0);
        quiet = 1'b0;
    endtask

    // Write transfer: wbuf[0] is the pointer byte, wbuf[1..n-1] data
    task automatic wr_txn(input logic [6:0] addr, input int n, input bit do_stop);
        logic a;
        bit   match = (addr == 7'h50);
        quiet = !match;
        start_c();
        send_byte({addr, 1'b0}, a);
        check("addr_ack", {31'd0, a}, {31'd0, match});
        if (match) check("busy_after_addr", {31'd0, busy}, 32'd1);
        for (int k = 0; k < n; k++) begin
            if (match) begin
                if (k == 0) begin
                    ptr_m = int'(wbuf[0]) % 16;
                end else begin
                    exp_wr.push_back({8'(ptr_m), wbuf[k]});
                    mem_m[ptr_m] = wbuf[k];
                    ptr_m = (ptr_m + 1) % 16;
                end
            end
            send_byte(wbuf[k], a);
            check("data_ack", {31'd0, a}, {31'd0, match});
        end
        if (do_stop) finish_stop();
    endtask

    // Read transfer from the current pointer, ACK all but the last byte
    task automatic rd_txn(input int n);
        logic       a;
        logic [7:0] b;
        int         base;
        base = rd_cnt;
        start_c();
        send_byte({7'h50, 1'b1}, a);
        check("rd_addr_ack", {31'd0, a}, 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, k == n - 1);
            check("rd_data", {24'd0, b}, {24'd0, mem_m[ptr_m]});
            rbuf[k] = b;
            if (k < n - 1) ptr_m = (ptr_m + 1) % 16;
        end
        check("sda_rel_after_nack", {31'd0, sda_oe}, 32'd0);
        finish_stop();
        check("rd_strobes", rd_cnt - base, n);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check("rst_wr_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Pointer 3, data A5 5A
        wbuf[0] = 8'h03; wbuf[1] = 8'hA5; wbuf[2] = 8'h5A;
        wr_txn(7'h50, 3, 1'b1);
        // Set pointer 3, repeated START, read two bytes
        wbuf[0] = 8'h03;
        wr_txn(7'h50, 1, 1'b0);
        rd_txn(2);
        check("lit_rd0", {24'd0, rbuf[0]}, 32'hA5);
        check("lit_rd1", {24'd0, rbuf[1]}, 32'h5A);

        // Wrong address: never acknowledged, no strobes
        wbuf[0] = 8'h01; wbuf[1] = 8'h77;
        wr_txn(7'h51, 2, 1'b1);

        // Pointer wrap 15 -> 0
        wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        wr_txn(7'h50, 3, 1'b1);
        wbuf[0] = 8'h00;
        wr_txn(7'h50, 1, 1'b0);
        rd_txn(1);
        check("lit_wrap", {24'd0, rbuf[0]}, 32'h22);

        // STOP after four bits of a data byte: pointer set, nothing written
        wbuf[0] = 8'h05;
        wr_txn(7'h50, 1, 1'b0);
        for (int i = 7; i >= 4; i--) bit_xfer(wbuf[0][i] ^ 1'b1, s);
        finish_stop();
        rd_txn(1);

        // Reset during the address ACK slot
        start_c();
        for (int i = 6; i >= 0; i--) bit_xfer(7'h50 >> i, s);
        bit_xfer(1'b0, s);
        sda_m = 1'b1;
        wq();
        check("ack_driven_before_reset", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_releases_sda", {31'd0, sda_oe}, 32'd0);
        check("reset_releases_scl", {31'd0, scl_oe}, 32'd0);
        check("reset_clears_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        ptr_m = 0;
        exp_wr.delete();
        repeat (3) @(negedge clk);
        finish_stop();
        wbuf[0] = 8'h07; wbuf[1] = 8'hC6;
        wr_txn(7'h50, 2, 1'b1);
        wbuf[0] = 8'h06;
        wr_txn(7'h50, 1, 1'b0);
        rd_txn(2);
        check("lit_after_reset", {16'd0, rbuf[0], rbuf[1]}, 32'h00C6);

        // Random transfers
        for (int t = 0; t < 25; t++) begin
            int op, n;
            logic [6:0] ad;
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    wr_txn(7'h50, n, 1'b1);
                end
                1: begin
                    ad = 7'($urandom_range(0, 127));
                    if (ad == 7'h50) ad = 7'h00;
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    wr_txn(ad, n, 1'b1);
                end
                2: begin
                    wbuf[0] = 8'($urandom);
                    wr_txn(7'h50, 1, 1'b0);
                    rd_txn($urandom_range(1, 3));
                end
                default: rd_txn($urandom_range(1, 3));
            endcase
        end

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
